// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, byte type and defaults for the SPI slave byte front end.
package spi_pkg;
    localparam int SPI_BYTE_W = 8;
    localparam int BIT_CNT_W  = 3;

    typedef logic [SPI_BYTE_W-1:0] spi_byte_t;
    typedef logic [BIT_CNT_W-1:0]  bit_cnt_t;

    localparam spi_byte_t IDLE_BYTE_DEFAULT = 8'h00;
endpackage

// File: rtl/spi_byte_if.sv
// spi_byte_if: byte-wide valid/write/busy handshake between the SPI slave and a packet processor.
//   byte_recv, valid : received byte and its one-cycle strobe (slave -> processor)
//   write, byte_send : transmit request and byte (processor -> slave)
//   busy             : transmit holding register full (slave -> processor)
interface spi_byte_if;
    import spi_pkg::*;

    spi_byte_t byte_recv;
    logic      valid;
    logic      write;
    spi_byte_t byte_send;
    logic      busy;

    modport slave (output byte_recv, valid, busy, input write, byte_send);
    modport master (input byte_recv, valid, busy, output write, byte_send);
endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchroniser for one SPI pin plus rise/fall detection on the synchronised level.
//   clk, rst_L : system clock, asynchronous active-low reset
//   pin        : asynchronous input pin
//   level      : synchronised pin level
//   rise, fall : one-cycle pulses from the last two synchronised samples
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_L,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            sync <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], pin};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/spi_slave_byte_if.sv
// spi_slave_byte_if: SPI mode-0 slave front end, oversampled in clk, with byte-wide rx strobe and one-entry tx holding register.
//   clk, rst_L     : system clock (>= 8x SCLK), asynchronous active-low reset
//   sclk, cs_n     : SPI clock (CPOL=0) and active-low chip select
//   mosi, miso     : serial data in / out, MSB first
//   miso_en        : MISO pad enable while the frame is selected
//   bus (slave)    : byte_recv/valid out, write/byte_send in, busy out
module spi_slave_byte_if
    import spi_pkg::*;
#(
    parameter spi_byte_t IDLE_BYTE   = IDLE_BYTE_DEFAULT,
    parameter int        SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_L,
    input  logic      sclk,
    input  logic      cs_n,
    input  logic      mosi,
    output logic      miso,
    output logic      miso_en,
    spi_byte_if.slave bus
);
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_L(rst_L), .pin(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_L(rst_L), .pin(cs_n),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst_L(rst_L), .pin(mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    bit_cnt_t                bit_cnt;
    logic [SPI_BYTE_W-2:0]   rx_shift;
    spi_byte_t               tx_shift;
    spi_byte_t               holding;
    spi_byte_t               byte_recv;
    logic                    valid;
    logic                    busy;
    logic                    active;
    logic                    load;
    spi_byte_t               load_byte;

    assign active    = ~cs_s;
    // A tx load happens at frame start and on the falling edge that closes each byte.
    assign load      = cs_fall | (active & sclk_fall & (bit_cnt == '0));
    assign load_byte = busy ? holding : IDLE_BYTE;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            holding   <= '0;
            byte_recv <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            miso_en   <= 1'b0;
        end else begin
            valid <= 1'b0;
            // A load empties a full holding register; a write while full is dropped,
            // so a write coinciding with a load only lands when the register was empty.
            busy  <= busy ? ~load : bus.write;
            if (bus.write && !busy)
                holding <= bus.byte_send;
            if (cs_fall) begin
                bit_cnt  <= '0;
                tx_shift <= load_byte;
                miso_en  <= 1'b1;
            end else if (cs_rise) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                miso_en  <= 1'b0;
            end else if (active && sclk_rise) begin
                rx_shift <= {rx_shift[SPI_BYTE_W-3:0], mosi_s};
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == '1) begin
                    byte_recv <= {rx_shift, mosi_s};
                    valid     <= 1'b1;
                end
            end else if (active && sclk_fall) begin
                tx_shift <= (bit_cnt == '0) ? load_byte : {tx_shift[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    assign miso          = tx_shift[SPI_BYTE_W-1];
    assign bus.byte_recv = byte_recv;
    assign bus.valid     = valid;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_spi_slave_byte_if.sv
// tb_spi_slave_byte_if: self-checking bench for spi_slave_byte_if (vector table, corner sequences, random frames vs. byte-level model).
module tb_spi_slave_byte_if;
    import spi_pkg::*;

    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso, miso_en;

    spi_byte_if bus();

    spi_slave_byte_if #(.IDLE_BYTE(8'h00), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_L(rst_L), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_en(miso_en), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] recv_q[$];

    always @(negedge clk) if (bus.valid === 1'b1) recv_q.push_back(bus.byte_recv);

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] v);
        bus.byte_send = v;
        bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic cs_lo();
        cs_n = 1'b0;
        clks(H);
    endtask

    task automatic cs_hi();
        cs_n = 1'b1;
        clks(H);
    endtask

    task automatic xfer(input logic [7:0] m, input int nbits, input int wr_bit,
                        input logic [7:0] wr_val, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = m[7-i];
            if (i == wr_bit) begin
                do_write(wr_val);
                chk("busy_after_write", {31'b0, bus.busy}, 32'd1);
            end
            clks(H);
            got = {got[6:0], miso};
            sclk = 1'b1;
            clks(H);
            sclk = 1'b0;
        end
        clks(H);
    endtask

    function automatic logic [7:0] recv_at(input int i);
        return (recv_q.size() > i) ? recv_q[i] : 8'hxx;
    endfunction

    typedef struct {
        logic [7:0] mosi_b;
        bit         pre_wr;
        logic [7:0] wr_val;
        logic [7:0] exp_miso;
        logic [7:0] exp_recv;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] g, g2, held, exp_tx, wv;
        logic [7:0] mb[3];
        bit full;
        int nb, pre, wb;

        vecs[0] = '{8'hA5, 1'b0, 8'h00, 8'h00, 8'hA5};
        vecs[1] = '{8'h5A, 1'b1, 8'h3C, 8'h3C, 8'h5A};
        vecs[2] = '{8'h00, 1'b1, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 8'h01, 8'h01, 8'h81};
        vecs[5] = '{8'h7E, 1'b1, 8'h80, 8'h80, 8'h7E};

        bus.write = 1'b0;
        bus.byte_send = '0;
        clks(3);
        chk("rst_miso", {31'b0, miso}, 0);
        chk("rst_miso_en", {31'b0, miso_en}, 0);
        chk("rst_valid", {31'b0, bus.valid}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_byte_recv", {24'b0, bus.byte_recv}, 0);
        rst_L = 1'b1;
        clks(H);

        for (int v = 0; v < 6; v++) begin
            recv_q.delete();
            if (vecs[v].pre_wr) begin
                do_write(vecs[v].wr_val);
                chk("vec_busy_set", {31'b0, bus.busy}, 1);
            end
            cs_lo();
            xfer(vecs[v].mosi_b, 8, -1, 8'h00, g);
            cs_hi();
            chk("vec_miso", {24'b0, g}, {24'b0, vecs[v].exp_miso});
            chk("vec_valid_count", recv_q.size(), 1);
            chk("vec_recv", {24'b0, recv_at(0)}, {24'b0, vecs[v].exp_recv});
            chk("vec_busy_end", {31'b0, bus.busy}, 0);
        end

        // cs fall to first MISO bit latency, and busy clearing one cycle after cs_fall
        recv_q.delete();
        do_write(8'h96);
        cs_n = 1'b0;
        clks(2);
        chk("lat_busy_hold", {31'b0, bus.busy}, 1);
        chk("lat_miso_en_early", {31'b0, miso_en}, 0);
        clks(1);
        chk("lat_busy_clear", {31'b0, bus.busy}, 0);
        chk("lat_miso_en", {31'b0, miso_en}, 1);
        chk("lat_miso_msb", {31'b0, miso}, 1);
        clks(H - 3);
        xfer(8'h3C, 8, -1, 8'h00, g);
        cs_hi();
        chk("lat_miso_byte", {24'b0, g}, 32'h96);
        chk("lat_recv", {24'b0, recv_at(0)}, 32'h3C);
        chk("cs_hi_miso_en", {31'b0, miso_en}, 0);

        // write while busy is ignored
        recv_q.delete();
        do_write(8'h3C);
        do_write(8'hFF);
        chk("busy_ignore_busy", {31'b0, bus.busy}, 1);
        cs_lo();
        xfer(8'h00, 8, -1, 8'h00, g);
        cs_hi();
        chk("busy_ignore_miso", {24'b0, g}, 32'h3C);

        // two-byte frame with a write during byte 1
        recv_q.delete();
        cs_lo();
        xfer(8'h12, 8, 2, 8'h56, g);
        chk("two_busy_boundary", {31'b0, bus.busy}, 0);
        xfer(8'h34, 8, -1, 8'h00, g2);
        cs_hi();
        chk("two_miso_b1", {24'b0, g}, 0);
        chk("two_miso_b2", {24'b0, g2}, 32'h56);
        chk("two_valid_count", recv_q.size(), 2);
        chk("two_recv_b1", {24'b0, recv_at(0)}, 32'h12);
        chk("two_recv_b2", {24'b0, recv_at(1)}, 32'h34);

        // cs_n raised after 5 bits discards the partial byte
        recv_q.delete();
        cs_lo();
        xfer(8'hFF, 5, -1, 8'h00, g);
        cs_hi();
        chk("partial_no_valid", recv_q.size(), 0);
        chk("partial_miso_en", {31'b0, miso_en}, 0);
        cs_lo();
        xfer(8'h81, 8, -1, 8'h00, g);
        cs_hi();
        chk("partial_next_count", recv_q.size(), 1);
        chk("partial_next_recv", {24'b0, recv_at(0)}, 32'h81);

        // reset mid-byte while busy
        cs_lo();
        xfer(8'hFF, 3, 1, 8'hAA, g);
        rst_L = 1'b0;
        cs_n = 1'b1;
        #1;
        chk("rstmid_busy", {31'b0, bus.busy}, 0);
        chk("rstmid_miso_en", {31'b0, miso_en}, 0);
        chk("rstmid_miso", {31'b0, miso}, 0);
        chk("rstmid_valid", {31'b0, bus.valid}, 0);
        chk("rstmid_byte_recv", {24'b0, bus.byte_recv}, 0);
        clks(3);
        rst_L = 1'b1;
        clks(H);
        recv_q.delete();
        cs_lo();
        xfer(8'hC3, 8, -1, 8'h00, g);
        cs_hi();
        chk("rstmid_next_miso", {24'b0, g}, 0);
        chk("rstmid_next_recv", {24'b0, recv_at(0)}, 32'hC3);

        // random frames against a byte-level model of the holding register
        full = 1'b0;
        held = '0;
        for (int f = 0; f < 25; f++) begin
            recv_q.delete();
            nb = $urandom_range(1, 3);
            pre = $urandom_range(0, 2);
            for (int k = 0; k < pre; k++) begin
                wv = 8'($urandom);
                do_write(wv);
                if (!full) begin
                    held = wv;
                    full = 1'b1;
                end
            end
            for (int j = 0; j < nb; j++) mb[j] = 8'($urandom);
            cs_lo();
            exp_tx = full ? held : 8'h00;
            full = 1'b0;
            for (int j = 0; j < nb; j++) begin
                wb = $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : -1;
                wv = 8'($urandom);
                xfer(mb[j], 8, wb, wv, g);
                chk("rand_miso", {24'b0, g}, {24'b0, exp_tx});
                if (wb >= 0 && !full) begin
                    held = wv;
                    full = 1'b1;
                end
                exp_tx = full ? held : 8'h00;
                full = 1'b0;
            end
            cs_hi();
            chk("rand_busy_end", {31'b0, bus.busy}, {31'b0, full});
            chk("rand_valid_count", recv_q.size(), nb);
            for (int j = 0; j < nb; j++)
                chk("rand_recv", {24'b0, recv_at(j)}, {24'b0, mb[j]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_byte_if.md
Name: spi_slave_byte_if

Overview:
SPI mode-0 slave front end that converts the serial pins into the byte-wide valid/write/busy handshake used by the packet processors. All pin inputs are oversampled and synchronised into clk; there is no SCLK clock domain. Received bytes go to the downstream processor as one-cycle valid strobes. Bytes the processor writes are held in a one-entry transmit register and shifted out MSB-first on MISO.

Parameters:
IDLE_BYTE, 8'h00, byte shifted out on MISO when no transmit byte is held at a byte boundary
SYNC_STAGES, 2, synchroniser depth on sclk, cs_n and mosi; legal values 2..3

Ports:
clk  input  1  system clock; must run at least 8x the SCLK frequency
rst_L  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from master, CPOL=0
cs_n  input  1  SPI chip select, active low
mosi  input  1  master-out data
miso  output  1  slave-out data, MSB first
miso_en  output  1  high while the synchronised cs_n is low (pad tristate enable)
byte_recv  output  8  last completed received byte
valid  output  1  one-cycle strobe; byte_recv is valid in the same cycle
write  input  1  processor requests transmit of byte_send; accepted only when busy=0
byte_send  input  8  byte to transmit
busy  output  1  transmit holding register full

Behaviour:
- Reset is asynchronous, active-low, on clk; clk is the only clock. Reset values: miso=0, miso_en=0, byte_recv=0, valid=0, busy=0. Also cleared: bit counter, rx/tx shift registers, holding register, and the synchroniser edge history. Synchroniser flops reset to idle pin levels: sclk=0, cs_n=1.
- Sync: each pin passes through SYNC_STAGES flops. Edges are detected from the last two synchronised sclk/cs_n samples. rise/fall/cs_fall are one-cycle pulses.
- Frame is active while synchronised cs_n=0; sclk edges with cs_n high are ignored.
- cs_fall: bit_cnt<=0; tx_shift<=holding if busy, else IDLE_BYTE; busy clears the next cycle if it was set. miso_en rises in the same cycle.
- sclk rise (frame active): rx_shift<={rx_shift[6:0],mosi_s}; bit_cnt<=bit_cnt+1 (3-bit, wraps 7->0).
  - When bit_cnt was 7: byte_recv<={rx_shift[6:0],mosi_s} and valid=1 for the next cycle only.
- sclk fall (frame active):
  - if bit_cnt==0 (byte boundary): tx_shift<=holding if busy, else IDLE_BYTE; holding consumed.
  - otherwise: tx_shift<=tx_shift<<1.
- miso=tx_shift[7], registered. Latency from the cs_n pin falling to miso valid is SYNC_STAGES+1 clk cycles. The master must provide at least this much setup before the first SCLK rise.
- Write handshake: if write=1 and busy=0, holding<=byte_send and busy=1 next cycle. A write while busy=1 is ignored; no state changes.
- Simultaneous write and load point with busy=0: the load takes IDLE_BYTE and the write fills holding. Simultaneous load with busy=1 and write=1: the write is ignored (busy still 1 that cycle).
- cs_n deasserts mid-byte: the partial rx byte is discarded (no valid), bit_cnt<=0, miso_en<=0, and the tx_shift remainder is dropped. Holding and busy are retained.
- cs_n rising with bit_cnt==0: normal end of frame, no extra action.
- Reset mid-frame: all state returns to reset values immediately; the next frame starts only on a fresh cs_fall.

Decomposition:
- spi_pkg: SPI_BYTE_W=8, BIT_CNT_W=3, IDLE_BYTE default constant, and a typedef for the byte type shared with the processors.
- Sub-module spi_pin_sync: parameterised synchroniser plus rise/fall edge detector, one instance per pin (sclk, cs_n, mosi; edge outputs unused for mosi).

Test Plan:
- Frame with 8 sclk cycles, mosi=0xA5 -> exactly one valid pulse with byte_recv=8'hA5; miso shows IDLE_BYTE 0x00 bits.
- write=1, byte_send=0x3C before cs falls -> busy=1 until cs_fall+1; miso bits sampled on sclk rises = 0,0,1,1,1,1,0,0.
- 2-byte frame, mosi 0x12,0x34; processor writes 0x56 during byte 1 -> valid twice (0x12, 0x34); byte 2 miso = 0x56; busy falls at the byte-1/byte-2 boundary fall edge.
- write while busy=1 with byte_send=0xFF -> ignored; the originally held 0x3C is transmitted.
- cs_n raised after 5 bits, then a full frame with 0x81 -> no valid for the partial byte; the next frame yields byte_recv=0x81.
- rst_L pulsed low mid-byte with busy=1 -> all outputs 0, busy=0 immediately; a subsequent clean frame with 0xC3 receives correctly and transmits IDLE_BYTE.
